key_in: RTL and testbench

Single-pulse key-press conditioner for the Flappy Bird game's "flap" input. It synchronizes the raw asynchronous key level into the system clock domain and filters out bounce. It then emits exactly one clock-cycle pulse on `keyOut` for each press, however long the key is held. It sits between the board push-button (already inverted to active-high upstream) and the bird-motion control logic.

---
 rtl/key_in.sv | 65 ++++++
 tb/tb_key_in.sv | 134 +++++++++++++
 2 files changed

// File: rtl/key_in.sv
// Flap-key conditioner: synchronizes the raw key, debounces it, and emits one
// registered clock-cycle pulse per accepted press (releases are silent).
module key_in #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic keyOut
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   ks;
  logic                   stable;
  logic                   stable_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   rise;

  // synchronizer chain, sync[0] is the metastability-exposed flop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], key};
    end
  end

  assign ks = sync[SYNC_STAGES-1];

  // debounce: a disagreement must persist DEBOUNCE_CYCLES edges to be accepted;
  // cnt never passes CNT_LAST, so it cannot wrap
  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = '0;
    if (ks != stable) begin
      if (cnt == CNT_LAST) begin
        stable_nxt = ks;
        cnt_nxt    = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  assign rise = ~stable & stable_nxt;

  // accepted level, counter and press pulse all registered on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= 1'b0;
      cnt    <= '0;
      keyOut <= 1'b0;
    end else begin
      stable <= stable_nxt;
      cnt    <= cnt_nxt;
      keyOut <= rise;
    end
  end

endmodule

// File: tb/tb_key_in.sv
// Directed bench for key_in: default instance plus a DEBOUNCE_CYCLES=4 instance.
module tb_key_in;

  logic clk;
  logic reset;
  logic key;
  logic keyOut;
  logic key4;
  logic keyOut4;

  int checks;
  int failures;

  key_in u_dut (
    .clk    (clk),
    .reset  (reset),
    .key    (key),
    .keyOut (keyOut)
  );

  key_in #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) u_dut4 (
    .clk    (clk),
    .reset  (reset),
    .key    (key4),
    .keyOut (keyOut4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    key      = 1'b0;
    key4     = 1'b0;

    // reset held low for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_keyOut", 32'(keyOut), 32'd0);
      chk("rst_keyOut4", 32'(keyOut4), 32'd0);
    end
    chk("rst_sync", 32'(u_dut.sync), 32'd0);
    chk("rst_stable", 32'(u_dut.stable), 32'd0);
    chk("rst_cnt", 32'(u_dut.cnt), 32'd0);

    // long press: next edge is E0, pulse expected after E2 only
    reset = 1'b1;
    key   = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("press1_E%0d", k), 32'(keyOut), (k == 2) ? 32'd1 : 32'd0);
    end

    // release: no pulse
    key = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("release_E%0d", k), 32'(keyOut), 32'd0);
    end

    // second press
    key = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("press2_E%0d", k), 32'(keyOut), (k == 2) ? 32'd1 : 32'd0);
    end
    key = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("settle_stable", 32'(u_dut.stable), 32'd0);

    // DEBOUNCE_CYCLES=4: a 3-cycle glitch is rejected
    key4 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 2) key4 = 1'b0;
      chk($sformatf("glitch3_E%0d", k), 32'(keyOut4), 32'd0);
    end
    chk("glitch3_stable", 32'(u_dut4.stable), 32'd0);

    // 4-cycle press is accepted, pulse after E(2+4-1)=E5
    key4 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 3) key4 = 1'b0;
      chk($sformatf("press4_E%0d", k), 32'(keyOut4), (k == 5) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 8; k++) step();
    chk("press4_released", 32'(u_dut4.stable), 32'd0);

    // async reset while keyOut is high
    key = 1'b1;
    for (int k = 0; k < 3; k++) step();
    chk("midpulse_high", 32'(keyOut), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_keyOut", 32'(keyOut), 32'd0);
    chk("async_rst_stable", 32'(u_dut.stable), 32'd0);
    chk("async_rst_sync", 32'(u_dut.sync), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("held_in_rst", 32'(keyOut), 32'd0);
    end

    // key held across reset release: fresh press at default latency
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("held_rel_E%0d", k), 32'(keyOut), (k == 2) ? 32'd1 : 32'd0);
    end
    key = 1'b0;
    for (int k = 0; k < 4; k++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
